// File: rtl/pmem_scheduler.sv
// Purpose     : arbitrates the single pmem wishbone port between L2 line fills and EWB drains.
// Latency     : read ack 1 cycle after pm_ack; forwarded read ack 2 cycles after rd_req seen in IDLE.
// Backpressure: requests are level-held until their ack; one transfer per wishbone cycle, no pipelining.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   rd_req/rd_adr           L2 fill request (held until rd_ack) and line address
//   rd_dat/rd_ack           fill data and its 1-cycle completion pulse
//   wb_valid/wb_adr/wb_dat  EWB dirty line waiting to drain
//   wb_ack                  1-cycle pulse once the EWB line is written to memory
//   pm_*                    wishbone master towards pmembus (pm_sel tied all-ones)
//   busy                    scheduler is not idle
module pmem_scheduler #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4,
  parameter int FORWARD_EN   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_adr,
  output logic [DATA_W-1:0]   rd_dat,
  output logic                rd_ack,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_adr,
  input  logic [DATA_W-1:0]   wb_dat,
  output logic                wb_ack,
  output logic                pm_cyc,
  output logic                pm_stb,
  output logic                pm_we,
  output logic [ADDR_W-1:0]   pm_adr,
  output logic [DATA_W-1:0]   pm_dat_m,
  output logic [DATA_W/8-1:0] pm_sel,
  input  logic                pm_ack,
  input  logic [DATA_W-1:0]   pm_dat_s,
  output logic                busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FWD,
    S_RACK,
    S_WACK
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   starve_cnt;
  logic               starved;
  logic               adr_match;
  logic               enter_rd;
  logic               enter_wr;
  logic               enter_fwd;
  logic               nxt_on_bus;

  // Every byte lane is always written: the EWB only ever holds whole lines.
  assign pm_sel = '1;

  assign starved   = (starve_cnt == CNT_W'(STARVE_LIMIT));
  // A read to the line still sitting in the EWB would fetch stale memory data.
  assign adr_match = rd_req & wb_valid & (rd_adr == wb_adr);

  // Next-state logic; request inputs are only looked at while idle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (adr_match) begin
          state_nxt = (FORWARD_EN != 0) ? S_FWD : S_WR;
        end else if (wb_valid & (~rd_req | starved)) begin
          state_nxt = S_WR;
        end else if (rd_req) begin
          state_nxt = S_RD;
        end
      end
      S_RD:    if (pm_ack) state_nxt = S_RACK;
      S_WR:    if (pm_ack) state_nxt = S_WACK;
      // Forwarded data is already captured; the ack goes out through RACK,
      // which keeps forwarded and memory reads on the same ack path.
      S_FWD:   state_nxt = S_RACK;
      // The IDLE cycle after each ack gives the requester time to drop or
      // advance its request, so nothing is served twice.
      S_RACK:  state_nxt = S_IDLE;
      S_WACK:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_rd   = (state == S_IDLE) && (state_nxt == S_RD);
  assign enter_wr   = (state == S_IDLE) && (state_nxt == S_WR);
  assign enter_fwd  = (state == S_IDLE) && (state_nxt == S_FWD);
  assign nxt_on_bus = (state_nxt == S_RD) || (state_nxt == S_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reads that bypass a waiting write are counted; once the limit is reached
  // the write is forced ahead of the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (enter_wr) begin
      starve_cnt <= '0;
    end else if ((enter_rd | enter_fwd) & wb_valid & ~starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // All outputs are registered and decoded from the state being entered, so
  // the bus strobes are up from the first cycle of RD/WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_cyc   <= 1'b0;
      pm_stb   <= 1'b0;
      pm_we    <= 1'b0;
      pm_adr   <= '0;
      pm_dat_m <= '0;
      rd_dat   <= '0;
      rd_ack   <= 1'b0;
      wb_ack   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pm_cyc <= nxt_on_bus;
      pm_stb <= nxt_on_bus;
      pm_we  <= (state_nxt == S_WR);
      rd_ack <= (state_nxt == S_RACK);
      wb_ack <= (state_nxt == S_WACK);
      busy   <= (state_nxt != S_IDLE);

      // Address and write data are latched on entry; live inputs may change
      // while the bus cycle is in flight.
      if (enter_rd) begin
        pm_adr <= rd_adr;
      end else if (enter_wr) begin
        pm_adr <= wb_adr;
      end else if (!nxt_on_bus) begin
        pm_adr <= '0;
      end

      if (enter_wr) begin
        pm_dat_m <= wb_dat;
      end else if (state_nxt != S_WR) begin
        pm_dat_m <= '0;
      end

      // rd_dat holds its value between reads.
      if (enter_fwd) begin
        rd_dat <= wb_dat;
      end else if ((state == S_RD) && pm_ack) begin
        rd_dat <= pm_dat_s;
      end
    end
  end

endmodule

// File: tb/tb_pmem_scheduler.sv
// Purpose     : self-checking bench for pmem_scheduler (forwarding and non-forwarding builds).
// Latency     : pmem slave acks a configurable number of cycles after strobe.
// Backpressure: bench requesters drop or advance their request on the matching ack.
module tb_pmem_scheduler;

  localparam int AW = 12;
  localparam int DW = 128;

  localparam logic [3:0] K_PMRD = 4'd1;
  localparam logic [3:0] K_PMWR = 4'd2;
  localparam logic [3:0] K_RACK = 4'd3;
  localparam logic [3:0] K_WACK = 4'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_adr = '0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_adr = '0;
  logic [DW-1:0] wb_dat = '0;
  logic          pm_ack = 1'b0;
  logic [DW-1:0] pm_dat_s = '0;

  logic [DW-1:0]   a_rd_dat, b_rd_dat, rd_dat;
  logic            a_rd_ack, b_rd_ack, rd_ack;
  logic            a_wb_ack, b_wb_ack, wb_ack;
  logic            a_pm_cyc, b_pm_cyc, pm_cyc;
  logic            a_pm_stb, b_pm_stb, pm_stb;
  logic            a_pm_we, b_pm_we, pm_we;
  logic [AW-1:0]   a_pm_adr, b_pm_adr, pm_adr;
  logic [DW-1:0]   a_pm_dat_m, b_pm_dat_m, pm_dat_m;
  logic [DW/8-1:0] a_pm_sel, b_pm_sel, pm_sel;
  logic            a_busy, b_busy, busy;

  always #5 clk = ~clk;

  // sel=0 exercises the forwarding build, sel=1 the non-forwarding one;
  // the unselected instance is held in reset.
  pmem_scheduler #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .FORWARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n & ~sel),
    .rd_req(rd_req), .rd_adr(rd_adr), .rd_dat(a_rd_dat), .rd_ack(a_rd_ack),
    .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_ack(a_wb_ack),
    .pm_cyc(a_pm_cyc), .pm_stb(a_pm_stb), .pm_we(a_pm_we), .pm_adr(a_pm_adr),
    .pm_dat_m(a_pm_dat_m), .pm_sel(a_pm_sel), .pm_ack(pm_ack & ~sel),
    .pm_dat_s(pm_dat_s), .busy(a_busy)
  );

  pmem_scheduler #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .FORWARD_EN(0)) dut_nf (
    .clk(clk), .rst_n(rst_n & sel),
    .rd_req(rd_req), .rd_adr(rd_adr), .rd_dat(b_rd_dat), .rd_ack(b_rd_ack),
    .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_ack(b_wb_ack),
    .pm_cyc(b_pm_cyc), .pm_stb(b_pm_stb), .pm_we(b_pm_we), .pm_adr(b_pm_adr),
    .pm_dat_m(b_pm_dat_m), .pm_sel(b_pm_sel), .pm_ack(pm_ack & sel),
    .pm_dat_s(pm_dat_s), .busy(b_busy)
  );

  assign rd_dat   = sel ? b_rd_dat   : a_rd_dat;
  assign rd_ack   = sel ? b_rd_ack   : a_rd_ack;
  assign wb_ack   = sel ? b_wb_ack   : a_wb_ack;
  assign pm_cyc   = sel ? b_pm_cyc   : a_pm_cyc;
  assign pm_stb   = sel ? b_pm_stb   : a_pm_stb;
  assign pm_we    = sel ? b_pm_we    : a_pm_we;
  assign pm_adr   = sel ? b_pm_adr   : a_pm_adr;
  assign pm_dat_m = sel ? b_pm_dat_m : a_pm_dat_m;
  assign pm_sel   = sel ? b_pm_sel   : a_pm_sel;
  assign busy     = sel ? b_busy     : a_busy;

  int            total = 0;
  int            bad = 0;
  int            cyc_n = 0;
  int            ack_dly = 0;
  int            wait_cnt = 0;
  int            pm_ack_cyc = 0;
  int            rd_ack_cyc = 0;
  logic [15:0]   ev_q[$];
  logic [15:0]   exp_q[$];
  logic [AW-1:0] rd_next_q[$];
  logic [DW-1:0] last_rd_dat = '0;
  logic [DW-1:0] last_wdat = '0;
  logic [DW-1:0] rd_datm_acc = '0;

  function automatic logic [15:0] ev(input logic [3:0] k, input logic [AW-1:0] a);
    return {k, a};
  endfunction

  function automatic logic [3:0][15:0] evs(input logic [15:0] e0, e1, e2, e3);
    logic [3:0][15:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One cycle of bench time, at the falling edge: log DUT events, let the
  // requesters react to acks, and run the pmem slave.
  task automatic tick();
    @(negedge clk);
    cyc_n++;
    if (rd_ack) begin
      ev_q.push_back(ev(K_RACK, '0));
      last_rd_dat = rd_dat;
      rd_ack_cyc  = cyc_n;
      if (rd_next_q.size() > 0) rd_adr = rd_next_q.pop_front();
      else rd_req = 1'b0;
    end
    if (wb_ack) begin
      ev_q.push_back(ev(K_WACK, '0));
      wb_valid = 1'b0;
    end
    if (pm_ack) begin
      pm_ack = 1'b0;
    end else if (pm_stb) begin
      if (wait_cnt >= ack_dly) begin
        pm_ack     = 1'b1;
        wait_cnt   = 0;
        pm_ack_cyc = cyc_n;
        ev_q.push_back(ev(pm_we ? K_PMWR : K_PMRD, pm_adr));
        if (pm_we) last_wdat = pm_dat_m;
        else rd_datm_acc = rd_datm_acc | pm_dat_m;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic run_until_idle(input string nm, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = !rd_req && !wb_valid && !busy && !pm_cyc;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: rd_req=%0b wb_valid=%0b busy=%0b after %0d cycles, want all 0",
               nm, rd_req, wb_valid, busy, budget);
    end
  endtask

  task automatic check_ev(input string nm);
    chk({nm, "_nev"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      chk($sformatf("%s_ev%0d", nm, i), ev_q[i], exp_q[i]);
  endtask

  typedef struct {
    string            nm;
    logic             sel;
    int               dly;
    logic             rd;
    logic [AW-1:0]    ra;
    logic             wb;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [DW-1:0]    md;
    int               nev;
    logic [3:0][15:0] evl;
    logic [DW-1:0]    exp_rd;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [DW-1:0] a5, dead, fill, cafe, bad_md, fwd_d;
    int start;
    a5     = {16{8'hA5}};
    dead   = {8{16'hDEAD}};
    fill   = {4{32'h5A5A_0F0F}};
    cafe   = {8{16'hCAFE}};
    bad_md = {8{16'h0BAD}};
    fwd_d  = {4{32'h1234_5678}};

    vt[0] = '{"rd_only", 1'b0, 3, 1'b1, 12'h123, 1'b0, 12'h000, '0, a5, 2,
              evs(ev(K_PMRD, 12'h123), ev(K_RACK, 12'h0), 16'h0, 16'h0), a5};
    vt[1] = '{"rd_then_wr", 1'b0, 1, 1'b1, 12'h010, 1'b1, 12'h020, cafe, fill, 4,
              evs(ev(K_PMRD, 12'h010), ev(K_RACK, 12'h0), ev(K_PMWR, 12'h020), ev(K_WACK, 12'h0)), fill};
    vt[2] = '{"forward", 1'b0, 2, 1'b1, 12'h040, 1'b1, 12'h040, dead, a5, 3,
              evs(ev(K_RACK, 12'h0), ev(K_PMWR, 12'h040), ev(K_WACK, 12'h0), 16'h0), dead};
    vt[3] = '{"wr_only", 1'b0, 0, 1'b0, 12'h000, 1'b1, 12'h7FF, cafe, '0, 2,
              evs(ev(K_PMWR, 12'h7FF), ev(K_WACK, 12'h0), 16'h0, 16'h0), '0};
    vt[4] = '{"raw_nofwd", 1'b1, 1, 1'b1, 12'h040, 1'b1, 12'h040, dead, bad_md, 4,
              evs(ev(K_PMWR, 12'h040), ev(K_WACK, 12'h0), ev(K_PMRD, 12'h040), ev(K_RACK, 12'h0)), bad_md};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_pm_cyc", pm_cyc, 0);
    chk("rst_pm_stb", pm_stb, 0);
    chk("rst_pm_we", pm_we, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_wb_ack", wb_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pm_adr", pm_adr, 0);
    chk("rst_pm_dat_m", pm_dat_m, 0);
    chk("rst_pm_sel", pm_sel, {(DW/8){1'b1}});
    rst_n = 1'b1;
    repeat (2) tick();

    // Table-driven single-transaction arbitration vectors.
    for (int v = 0; v < 5; v++) begin
      if (sel != vt[v].sel) begin
        sel = vt[v].sel;
        repeat (2) tick();
      end
      ev_q.delete();
      exp_q.delete();
      for (int i = 0; i < vt[v].nev; i++) exp_q.push_back(vt[v].evl[i]);
      ack_dly  = vt[v].dly;
      pm_dat_s = vt[v].md;
      rd_req   = vt[v].rd;
      rd_adr   = vt[v].ra;
      wb_valid = vt[v].wb;
      wb_adr   = vt[v].wa;
      wb_dat   = vt[v].wd;
      run_until_idle(vt[v].nm, 40);
      check_ev(vt[v].nm);
      if (vt[v].rd) chk({vt[v].nm, "_rd_dat"}, last_rd_dat, vt[v].exp_rd);
      if (vt[v].wb) chk({vt[v].nm, "_wdat"}, last_wdat, vt[v].wd);
      tick();
    end
    chk("rd_pm_dat_m_zero", rd_datm_acc, '0);

    // Back to the forwarding build (its reset clears any history).
    sel = 1'b0;
    repeat (2) tick();

    // Read latency: rd_ack exactly one cycle after the pm_ack cycle.
    ack_dly  = 2;
    pm_dat_s = fill;
    rd_req   = 1'b1;
    rd_adr   = 12'h200;
    run_until_idle("rd_lat", 30);
    chk("rd_lat", rd_ack_cyc - pm_ack_cyc, 1);
    chk("rd_lat_busy", busy, 0);

    // Forward latency: rd_ack two cycles after the request is seen in IDLE.
    ev_q.delete();
    wb_valid = 1'b1;
    wb_adr   = 12'h300;
    wb_dat   = fwd_d;
    rd_req   = 1'b1;
    rd_adr   = 12'h300;
    start    = cyc_n;
    run_until_idle("fwd_lat", 30);
    chk("fwd_lat", rd_ack_cyc - start, 2);
    chk("fwd_lat_dat", last_rd_dat, fwd_d);
    chk("fwd_lat_first_ev", ev_q.size() > 0 ? ev_q[0] : 16'h0, ev(K_RACK, 12'h0));

    // Starvation: four reads pass the waiting write, then it is forced.
    ev_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev(K_PMRD, 12'h100 + 12'(i)));
      exp_q.push_back(ev(K_RACK, 12'h0));
    end
    exp_q.push_back(ev(K_PMWR, 12'h0F0));
    exp_q.push_back(ev(K_WACK, 12'h0));
    for (int i = 4; i < 6; i++) begin
      exp_q.push_back(ev(K_PMRD, 12'h100 + 12'(i)));
      exp_q.push_back(ev(K_RACK, 12'h0));
    end
    for (int i = 1; i < 6; i++) rd_next_q.push_back(12'h100 + 12'(i));
    ack_dly  = 1;
    wb_valid = 1'b1;
    wb_adr   = 12'h0F0;
    wb_dat   = cafe;
    rd_req   = 1'b1;
    rd_adr   = 12'h100;
    run_until_idle("starve", 200);
    check_ev("starve");
    chk("starve_wdat", last_wdat, cafe);

    // Reset one cycle into RD: bus drops at once, no ack, read re-issued.
    ev_q.delete();
    ack_dly  = 3;
    pm_dat_s = a5;
    rd_req   = 1'b1;
    rd_adr   = 12'h123;
    for (int i = 0; i < 8 && !pm_cyc; i++) tick();
    chk("rst_mid_cyc_seen", pm_cyc, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pm_cyc", pm_cyc, 0);
    chk("rst_mid_pm_stb", pm_stb, 0);
    chk("rst_mid_busy", busy, 0);
    tick();
    chk("rst_mid_rd_ack", rd_ack, 0);
    chk("rst_mid_no_ev", ev_q.size(), 0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(ev(K_PMRD, 12'h123));
    exp_q.push_back(ev(K_RACK, 12'h0));
    run_until_idle("rst_reissue", 40);
    check_ev("rst_reissue");
    chk("rst_reissue_dat", last_rd_dat, a5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
